// File: rtl/dcache_ctrl_pkg.sv
// Shared constants, FSM state encodings and address-split helpers for dcache_ctrl.
package dcache_ctrl_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEF_LINES = 16;
    localparam int unsigned DEF_WPL   = 4;
    localparam int unsigned DEF_CNT_W = 32;

    // Controller states
    localparam int unsigned         STATE_W   = 2;
    localparam logic [STATE_W-1:0]  ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0]  ST_REFILL = 2'd1;
    localparam logic [STATE_W-1:0]  ST_WRITE  = 2'd2;
    localparam logic [STATE_W-1:0]  ST_RESP   = 2'd3;

    // Tag width left over once the byte, offset and index bits are removed
    function automatic int unsigned tag_bits(input int unsigned lines, input int unsigned wpl);
        return ADDR_W - 2 - $clog2(wpl) - $clog2(lines);
    endfunction

    // Extract an address field of 'width' bits starting at bit 'lsb'
    function automatic logic [ADDR_W-1:0] addr_field(input logic [ADDR_W-1:0] addr,
                                                     input int unsigned       lsb,
                                                     input int unsigned       width);
        logic [ADDR_W-1:0] mask;
        mask = (width >= ADDR_W) ? '1 : ((ADDR_W'(1) << width) - ADDR_W'(1));
        return (addr >> lsb) & mask;
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU data-port and main-memory bus bundle for dcache_ctrl.
// slave  : cache-controller view (CPU request and memory response in).
// master : environment view (drives CPU request and memory response).
interface dcache_ctrl_if;
    import dcache_ctrl_pkg::*;

    logic              cpu_read_i;
    logic              cpu_write_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              stall_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    modport slave (
        input  cpu_read_i, cpu_write_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        output cpu_rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output cpu_read_i, cpu_write_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        input  cpu_rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage for a direct-mapped cache.
// Ports: idx_i selects the line for both read and write; off_i selects the
// read word (combinational valid_o/tag_o/data_o); word_we_i writes word_data_i
// at word_off_i; tag_we_i writes tag_i and marks the line valid.
// Valid bits clear on rst_i; tag and data contents are not reset.
module dcache_array
    import dcache_ctrl_pkg::*;
#(
    parameter  int unsigned LINES          = DEF_LINES,
    parameter  int unsigned WORDS_PER_LINE = DEF_WPL,
    parameter  int unsigned TAG_W          = tag_bits(DEF_LINES, DEF_WPL),
    localparam int unsigned IDX_W          = $clog2(LINES),
    localparam int unsigned OFF_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [OFF_W-1:0]  off_i,
    output logic              valid_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              word_we_i,
    input  logic [OFF_W-1:0]  word_off_i,
    input  logic [DATA_W-1:0] word_data_i,
    input  logic              tag_we_i,
    input  logic [TAG_W-1:0]  tag_i
);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES][WORDS_PER_LINE];

    // A tag write completes a refill, so it also validates the line
    always_comb begin
        valid_d = valid_q;
        if (tag_we_i) begin
            valid_d[idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Storage without reset
    always_ff @(posedge clk_i) begin
        if (tag_we_i) begin
            tag_q[idx_i] <= tag_i;
        end
        if (word_we_i) begin
            data_q[idx_i][word_off_i] <= word_data_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i][off_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Ports: clk_i/rst_i (sync, active-high); bus (slave modport) carries the CPU
// load/store request, load data, stall, and the request/ack memory bus;
// hit_count_o/miss_count_o are saturating access statistics.
// Read hits complete in the lookup cycle; read misses refill a whole line;
// stores always go to memory and update the line only when it is present.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int unsigned LINES          = DEF_LINES,
    parameter int unsigned WORDS_PER_LINE = DEF_WPL,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dcache_ctrl_if.slave     bus,
    output logic [CNT_W-1:0] hit_count_o,
    output logic [CNT_W-1:0] miss_count_o
);

    localparam int unsigned OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W   = $clog2(LINES);
    localparam int unsigned TAG_W   = tag_bits(LINES, WORDS_PER_LINE);
    localparam int unsigned OFF_LSB = 2;
    localparam int unsigned IDX_LSB = OFF_LSB + OFF_W;
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [STATE_W-1:0] state_q, state_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic               wr_hit_q, wr_hit_d;

    logic [OFF_W-1:0]   addr_off;
    logic [IDX_W-1:0]   addr_idx;
    logic [TAG_W-1:0]   addr_tag;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [DATA_W-1:0]  line_data;
    logic               lookup_hit;
    logic               is_write;
    logic               is_read;

    logic               word_we;
    logic [OFF_W-1:0]   word_off;
    logic [DATA_W-1:0]  word_data;
    logic               tag_we;

    // Address split
    assign addr_off = OFF_W'(addr_field(bus.cpu_addr_i, OFF_LSB, OFF_W));
    assign addr_idx = IDX_W'(addr_field(bus.cpu_addr_i, IDX_LSB, IDX_W));
    assign addr_tag = TAG_W'(addr_field(bus.cpu_addr_i, TAG_LSB, TAG_W));

    dcache_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_array (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (addr_idx),
        .off_i       (addr_off),
        .valid_o     (line_valid),
        .tag_o       (line_tag),
        .data_o      (line_data),
        .word_we_i   (word_we),
        .word_off_i  (word_off),
        .word_data_i (word_data),
        .tag_we_i    (tag_we),
        .tag_i       (addr_tag)
    );

    assign lookup_hit = line_valid && (line_tag == addr_tag);
    // A simultaneous read and write request is handled as a write
    assign is_write   = bus.cpu_write_i;
    assign is_read    = bus.cpu_read_i && !bus.cpu_write_i;

    // Next-state, counters, array writes and bus outputs
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        hit_cnt_d       = hit_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        wr_hit_d        = wr_hit_q;
        word_we         = 1'b0;
        word_off        = addr_off;
        word_data       = bus.cpu_wdata_i;
        tag_we          = 1'b0;
        bus.stall_o     = 1'b0;
        bus.cpu_rdata_o = '0;
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;

        // Outputs and array writes stay quiet while reset is asserted
        if (!rst_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_write) begin
                        bus.stall_o = 1'b1;
                        wr_hit_d    = lookup_hit;
                        if (lookup_hit) begin
                            if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                        end else begin
                            if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                        end
                        state_d = ST_WRITE;
                    end else if (is_read) begin
                        if (lookup_hit) begin
                            bus.cpu_rdata_o = line_data;
                            if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                        end else begin
                            bus.stall_o = 1'b1;
                            if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                            cnt_d   = '0;
                            state_d = ST_REFILL;
                        end
                    end
                end

                ST_REFILL: begin
                    bus.stall_o    = 1'b1;
                    bus.mem_req_o  = 1'b1;
                    bus.mem_addr_o = {bus.cpu_addr_i[ADDR_W-1:IDX_LSB], cnt_q, 2'b00};
                    word_off       = cnt_q;
                    word_data      = bus.mem_rdata_i;
                    if (bus.mem_ack_i) begin
                        word_we = 1'b1;
                        cnt_d   = cnt_q + OFF_W'(1);
                        if (cnt_q == LAST_WORD) begin
                            tag_we  = 1'b1;
                            state_d = ST_RESP;
                        end
                    end
                end

                ST_WRITE: begin
                    bus.stall_o     = 1'b1;
                    bus.mem_req_o   = 1'b1;
                    bus.mem_we_o    = 1'b1;
                    bus.mem_addr_o  = {bus.cpu_addr_i[ADDR_W-1:2], 2'b00};
                    bus.mem_wdata_o = bus.cpu_wdata_i;
                    if (bus.mem_ack_i) begin
                        word_we = wr_hit_q;
                        state_d = ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (is_read) begin
                        bus.cpu_rdata_o = line_data;
                    end
                    state_d = ST_IDLE;
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wr_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wr_hit_q   <= wr_hit_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: expected memory transactions and load data
// are queued from a reference cache/memory model as each access is issued and
// checked when the DUT bus or CPU port produces them.
module tb_dcache_ctrl;

    localparam int unsigned CNT_W   = 3;
    localparam int          CNT_MAX = 7;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    dcache_ctrl_if bus_if ();

    dcache_ctrl #(
        .LINES          (16),
        .WORDS_PER_LINE (4),
        .CNT_W          (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus_if),
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    txn_t        exp_mem_q [$];
    logic [31:0] exp_rd_q  [$];
    logic [31:0] mem_phys  [logic [31:0]];
    logic [31:0] mem_model [logic [31:0]];
    bit          m_valid   [16];
    logic [23:0] m_tag     [16];
    int          m_hits;
    int          m_miss;

    int mem_lat  = 1;
    bit ack_tied = 0;
    int wait_cnt = 0;
    int ack_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return mem_phys.exists(a) ? mem_phys[a] : dflt(a);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : dflt(a);
    endfunction

    function automatic void bump(input bit hit);
        if (hit) begin
            if (m_hits < CNT_MAX) m_hits++;
        end else begin
            if (m_miss < CNT_MAX) m_miss++;
        end
    endfunction

    // Serve the current request: check it against the next expected transaction
    task automatic serve();
        txn_t e;
        bus_if.mem_ack_i = 1'b1;
        ack_seen++;
        if (exp_mem_q.size() == 0) begin
            chk("mem_unexpected_req", bus_if.mem_addr_o, 32'hFFFF_FFFF);
        end else begin
            e = exp_mem_q.pop_front();
            chk("mem_we", 32'(bus_if.mem_we_o), 32'(e.we));
            chk("mem_addr", bus_if.mem_addr_o, e.addr);
            if (e.we) chk("mem_wdata", bus_if.mem_wdata_o, e.wdata);
        end
        if (bus_if.mem_we_o) mem_phys[bus_if.mem_addr_o] = bus_if.mem_wdata_o;
        else bus_if.mem_rdata_i = phys_rd(bus_if.mem_addr_o);
    endtask

    // Main-memory responder: ack after mem_lat request cycles, or every cycle when tied
    always @(negedge clk) begin
        if (ack_tied) begin
            bus_if.mem_ack_i   = 1'b1;
            bus_if.mem_rdata_i = 32'hBAD0_0000;
            if (bus_if.mem_req_o) serve();
        end else if (bus_if.mem_req_o) begin
            wait_cnt++;
            if (wait_cnt >= mem_lat) begin
                wait_cnt = 0;
                serve();
            end else begin
                bus_if.mem_ack_i = 1'b0;
            end
        end else begin
            bus_if.mem_ack_i = 1'b0;
            wait_cnt         = 0;
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
        exp_mem_q.delete();
        exp_rd_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst                = 1'b1;
        bus_if.cpu_read_i  = 1'b0;
        bus_if.cpu_write_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
    endtask

    // Issue one CPU access, hold it until the stall drops, and check the result
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input int lat);
        logic [3:0]  idx;
        logic [23:0] tag;
        logic [31:0] word;
        logic [31:0] base;
        bit          hit;
        int          exp_stall;
        int          stall_cycles;
        bit          done;

        idx      = addr[7:4];
        tag      = addr[31:8];
        word     = {addr[31:2], 2'b00};
        base     = {addr[31:4], 4'b0000};
        hit      = m_valid[idx] && (m_tag[idx] == tag);
        mem_lat  = lat;

        if (wr) begin
            bump(hit);
            exp_mem_q.push_back('{we: 1'b1, addr: word, wdata: wd});
            mem_model[word] = wd;
            exp_stall = 1 + lat;
        end else if (hit) begin
            bump(1'b1);
            exp_stall = 0;
        end else begin
            bump(1'b0);
            for (int k = 0; k < 4; k++)
                exp_mem_q.push_back('{we: 1'b0, addr: base + 32'(4 * k), wdata: 32'h0});
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            exp_stall    = 1 + 4 * lat;
        end
        if (!wr) exp_rd_q.push_back(model_rd(word));

        bus_if.cpu_addr_i  = addr;
        bus_if.cpu_wdata_i = wd;
        bus_if.cpu_write_i = wr;
        bus_if.cpu_read_i  = !wr;
        #1;
        stall_cycles = 0;
        done         = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (!bus_if.stall_o) begin
                done = 1'b1;
            end else begin
                stall_cycles++;
                @(posedge clk);
                @(negedge clk);
                #1;
            end
        end
        if (!done) chk("access_timeout", 32'(stall_cycles), 32'(exp_stall));
        chk("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
        if (!wr && exp_rd_q.size() != 0) chk("load_data", bus_if.cpu_rdata_o, exp_rd_q.pop_front());

        @(posedge clk);
        @(negedge clk);
        bus_if.cpu_read_i  = 1'b0;
        bus_if.cpu_write_i = 1'b0;
        #1;
        chk("hit_count", 32'(hit_count), 32'(m_hits));
        chk("miss_count", 32'(miss_count), 32'(m_miss));
        chk("mem_q_drained", 32'(exp_mem_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        bus_if.cpu_read_i  = 1'b0;
        bus_if.cpu_write_i = 1'b0;
        bus_if.cpu_addr_i  = '0;
        bus_if.cpu_wdata_i = '0;
        bus_if.mem_ack_i   = 1'b0;
        bus_if.mem_rdata_i = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_stall", 32'(bus_if.stall_o), 32'd0);
        chk("rst_mem_req", 32'(bus_if.mem_req_o), 32'd0);
        chk("rst_rdata", bus_if.cpu_rdata_o, 32'd0);
        chk("rst_hits", 32'(hit_count), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);

        // Cold read miss with two-cycle ack latency, then a hit in the same line
        access(1'b0, 32'h0000_0040, 32'h0, 2);
        access(1'b0, 32'h0000_0044, 32'h0, 2);

        // Conflicting lines on index 4
        do_reset();
        access(1'b0, 32'h0000_0040, 32'h0, 1);
        access(1'b0, 32'h0000_0140, 32'h0, 1);
        access(1'b0, 32'h0000_0040, 32'h0, 1);
        chk("conflict_miss", 32'(miss_count), 32'd3);

        // Write hit updates the line; following read hits with the new word
        do_reset();
        access(1'b0, 32'h0000_0040, 32'h0, 1);
        access(1'b1, 32'h0000_0048, 32'hDEAD_BEEF, 2);
        access(1'b0, 32'h0000_0048, 32'h0, 1);

        // Write miss does not allocate; the read afterwards refills the stored value
        do_reset();
        access(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 1);
        access(1'b0, 32'h0000_0200, 32'h0, 3);
        chk("wmiss_miss", 32'(miss_count), 32'd2);

        // Reset during a refill after two of four acks
        do_reset();
        mem_lat  = 2;
        ack_seen = 0;
        for (int k = 0; k < 4; k++)
            exp_mem_q.push_back('{we: 1'b0, addr: 32'h40 + 32'(4 * k), wdata: 32'h0});
        bus_if.cpu_addr_i = 32'h0000_0040;
        bus_if.cpu_read_i = 1'b1;
        for (int c = 0; c < 100 && ack_seen < 2; c++) begin
            @(negedge clk);
            #2;
        end
        chk("refill_acks_seen", 32'(ack_seen), 32'd2);
        @(posedge clk);
        @(negedge clk);
        rst               = 1'b1;
        bus_if.cpu_read_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(bus_if.mem_req_o), 32'd0);
        chk("midrst_stall", 32'(bus_if.stall_o), 32'd0);
        chk("midrst_hits", 32'(hit_count), 32'd0);
        chk("midrst_miss", 32'(miss_count), 32'd0);
        model_clear();
        access(1'b0, 32'h0000_0040, 32'h0, 2);

        // Ack tied high: spurious ack in IDLE, then the fastest possible refill
        do_reset();
        ack_tied = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("spurious_mem_req", 32'(bus_if.mem_req_o), 32'd0);
        chk("spurious_stall", 32'(bus_if.stall_o), 32'd0);
        chk("spurious_counts", 32'({hit_count, miss_count}), 32'd0);
        access(1'b0, 32'h0000_0080, 32'h0, 1);
        repeat (2) @(negedge clk);
        #1;
        chk("idle_ack_hits", 32'(hit_count), 32'd0);
        chk("idle_ack_miss", 32'(miss_count), 32'd1);
        ack_tied = 1'b0;

        // Hit counter saturates
        for (int i = 0; i < 9; i++)
            access(1'b0, 32'h0000_0080 + 32'(4 * (i % 4)), 32'h0, 1);
        chk("hit_saturate", 32'(hit_count), 32'(CNT_MAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
